// File: rtl/snake_body_if.sv
// Snake body bundle: move strobe, direction request, apple map in; body map and status out.
//   tick        - move strobe, one move per high cycle
//   dirValid    - dirIn carries a new direction request
//   dirIn       - 00 up, 01 down, 10 left, 11 right
//   RedPixels   - apple map [row][col]
//   GreenPixels - snake body map [row][col]
//   win         - one-cycle pulse when an apple is eaten
//   died        - sticky collision flag
//   length      - current segment count (3..16)
interface snake_body_if;
  logic                   tick;
  logic                   dirValid;
  logic [1:0]             dirIn;
  logic [15:0][15:0]      RedPixels;
  logic [15:0][15:0]      GreenPixels;
  logic                   win;
  logic                   died;
  logic [4:0]             length;

  modport master (
    output tick, dirValid, dirIn, RedPixels,
    input  GreenPixels, win, died, length
  );

  modport slave (
    input  tick, dirValid, dirIn, RedPixels,
    output GreenPixels, win, died, length
  );
endinterface

// File: rtl/snake_body.sv
// Snake body: holds up to 16 segments, moves the head one cell per tick, grows on apples,
// and freezes on a wall or self collision.
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - snake_body_if slave (tick/dir/apples in, body map/win/died/length out)
module snake_body (
  input logic         clk,
  input logic         reset,
  snake_body_if.slave bus
);

  typedef enum logic [1:0] {StWait, StRun, StDead} state_e;

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirDown  = 2'b01;
  localparam logic [1:0] DirLeft  = 2'b10;
  localparam logic [1:0] DirRight = 2'b11;

  state_e     state_q, state_d;
  logic [3:0] row_q [16];
  logic [3:0] col_q [16];
  logic [3:0] row_d [16];
  logic [3:0] col_d [16];
  logic [4:0] length_q, length_d;
  logic [1:0] cur_dir_q, cur_dir_d;
  logic [1:0] req_dir_q, req_dir_d;
  logic       win_q, win_d;
  logic       died_q, died_d;

  logic       dir_accept;
  logic [1:0] move_dir;
  logic [3:0] next_row, next_col;
  logic       wall_hit, self_hit, grow;

  // Reverse of a direction flips only the low bit (up<->down, left<->right).
  assign dir_accept = bus.dirValid && (bus.dirIn != {cur_dir_q[1], ~cur_dir_q[0]});
  assign move_dir   = dir_accept ? bus.dirIn : req_dir_q;

  always_comb begin
    next_row = row_q[0];
    next_col = col_q[0];
    wall_hit = 1'b0;
    unique case (move_dir)
      DirUp: begin
        next_row = row_q[0] - 4'd1;
        wall_hit = (row_q[0] == 4'd0);
      end
      DirDown: begin
        next_row = row_q[0] + 4'd1;
        wall_hit = (row_q[0] == 4'd15);
      end
      DirLeft: begin
        next_col = col_q[0] - 4'd1;
        wall_hit = (col_q[0] == 4'd0);
      end
      DirRight: begin
        next_col = col_q[0] + 4'd1;
        wall_hit = (col_q[0] == 4'd15);
      end
      default: ;
    endcase
  end

  assign grow = bus.RedPixels[next_row][next_col];

  // The tail cell is vacated this move unless the snake grows into a longer body.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < length_q) begin
        if (!((5'(i) == length_q - 5'd1) && (!grow || length_q == 5'd16)) &&
            row_q[i] == next_row && col_q[i] == next_col) begin
          self_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StWait;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:  if (dir_accept) state_d = StRun;
      StRun:   if (bus.tick && (wall_hit || self_hit)) state_d = StDead;
      StDead:  state_d = StDead;
      default: state_d = StWait;
    endcase
  end

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    length_d  = length_q;
    cur_dir_d = cur_dir_q;
    req_dir_d = req_dir_q;
    win_d     = 1'b0;
    died_d    = died_q;
    unique case (state_q)
      StWait: begin
        if (dir_accept) req_dir_d = bus.dirIn;
      end
      StRun: begin
        if (bus.tick) begin
          cur_dir_d = move_dir;
          req_dir_d = move_dir;
          if (wall_hit || self_hit) begin
            died_d = 1'b1;
          end else begin
            for (int i = 1; i < 16; i++) begin
              row_d[i] = row_q[i-1];
              col_d[i] = col_q[i-1];
            end
            row_d[0] = next_row;
            col_d[0] = next_col;
            win_d    = grow;
            if (grow && length_q != 5'd16) length_d = length_q + 5'd1;
          end
        end else if (dir_accept) begin
          req_dir_d = bus.dirIn;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        row_q[i] <= 4'd0;
        col_q[i] <= 4'd0;
      end
      row_q[0]  <= 4'd8;
      col_q[0]  <= 4'd8;
      row_q[1]  <= 4'd8;
      col_q[1]  <= 4'd7;
      row_q[2]  <= 4'd8;
      col_q[2]  <= 4'd6;
      length_q  <= 5'd3;
      cur_dir_q <= DirRight;
      req_dir_q <= DirRight;
      win_q     <= 1'b0;
      died_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      length_q  <= length_d;
      cur_dir_q <= cur_dir_d;
      req_dir_q <= req_dir_d;
      win_q     <= win_d;
      died_q    <= died_d;
    end
  end

  always_comb begin
    bus.GreenPixels = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < length_q) bus.GreenPixels[row_q[i]][col_q[i]] = 1'b1;
    end
  end

  assign bus.win    = win_q;
  assign bus.died   = died_q;
  assign bus.length = length_q;

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, the single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port `reset`: input, 1 bit, synchronous active-high reset.
REQ-003 SHALL have port `tick`: input, 1 bit, move strobe; one move per cycle in which it is high.
REQ-004 SHALL have port `dirValid`: input, 1 bit, marks `dirIn` as a new direction request.
REQ-005 SHALL have port `dirIn`: input, 2 bits, encoded as 00 up (row-1), 01 down (row+1), 10 left (col-1), 11 right (col+1).
REQ-006 SHALL have port `RedPixels`: input, [15:0][15:0], apple map indexed [row][col], from the apple display stage.
REQ-007 SHALL have port `GreenPixels`: output, [15:0][15:0], snake body map indexed [row][col].
REQ-008 SHALL have port `win`: output, 1 bit, one-cycle pulse meaning an apple was eaten; this is the apple stage's `win` input.
REQ-009 SHALL have port `died`: output, 1 bit, sticky collision flag.
REQ-010 SHALL have port `length`: output, 5 bits, current segment count (3..16).

Function
REQ-011 SHALL hold up to 16 segments, each a 4-bit row and 4-bit col; segment 0 is the head.
REQ-012 SHALL drive `GreenPixels` as the combinational decode of segments 0..length-1 only; all other bits are 0.
REQ-013 SHALL implement states WAIT, RUN and DEAD.
REQ-014 SHALL hold current direction `curDir` and requested direction `reqDir`.
REQ-015 SHALL load `dirIn` into `reqDir` when `dirValid` is high, unless `dirIn` is the reverse of `curDir`; a reverse request is ignored.
REQ-016 SHALL, in WAIT, ignore `tick`, and go to RUN on the first accepted `dirValid`.
REQ-017 SHALL, in RUN on `tick`, commit the direction first: if `dirValid` is high in the same cycle and the request is accepted, that `dirIn` is used; otherwise `reqDir` is used. The committed value goes to `curDir`.
REQ-018 SHALL, in RUN on `tick`, compute the next head as the current head plus one step in `curDir`.
REQ-019 SHALL treat a step off the grid as a wall hit, with no wrap-around: row 0 moving up, row 15 moving down, col 0 moving left, col 15 moving right.
REQ-020 SHALL set `grow` = `RedPixels`[nextRow][nextCol].
REQ-021 SHALL detect a self hit when the next head equals any segment in 0..length-1; the tail segment (length-1) is excluded when `grow` is 0 or when length is already 16.
REQ-022 SHALL, on a wall or self hit: set `died`=1, go to DEAD, leave segments unchanged and not pulse `win`.
REQ-023 SHALL, on a legal move: shift segments (seg[i] <= seg[i-1]), write seg[0] <= next head, and update all of this on the edge ending the tick cycle (latency 1).
REQ-024 SHALL, on a legal move with `grow`=1: pulse `win` high for exactly the cycle after the tick cycle, and increment `length`, saturating at 16.
REQ-025 SHALL, at length 16 with `grow`=1: still pulse `win`; the tail advances and `length` stays 16.
REQ-026 SHALL drive `win`=0 in every cycle not covered by REQ-024 and REQ-025.
REQ-027 SHALL, in DEAD, ignore `tick`, `dirValid` and `RedPixels`; `GreenPixels` stays frozen and `died` stays 1 until `reset`.
REQ-028 SHALL not move the snake when `tick` is low.

Reset
REQ-029 SHALL, on `reset` high at a clock edge (including mid-RUN or in DEAD), load the following state: WAIT, segments (8,8), (8,7), (8,6), `length`=3, `curDir`=`reqDir`=right, `win`=0, `died`=0.
REQ-030 SHALL give `reset` priority over `tick` and `dirValid` in the same cycle.
REQ-031 SHALL make `GreenPixels` after reset have exactly bits [8][8], [8][7] and [8][6] set.

Verification
REQ-032 SHALL cover reset: assert reset for 1 cycle -> `GreenPixels` bits [8][6..8] only, `length`=3, `win`=0, `died`=0; `tick` pulses before any `dirValid` -> no change.
REQ-033 SHALL cover the wall hit: `dirValid` with right, then 7 ticks -> head at (8,15), `died`=0; 8th tick -> `died`=1 next cycle, body unchanged; further ticks -> no change.
REQ-034 SHALL cover eating: RedPixels[8][9]=1, `dirValid` right, 1 tick -> next cycle `win`=1 for one cycle, `length`=4, `GreenPixels` bits [8][9], [8][8], [8][7], [8][6].
REQ-035 SHALL cover the reverse request: in RUN heading right, `dirValid` with left then tick -> head col+1 (request ignored); `dirValid` with up then tick -> head row-1.
REQ-036 SHALL cover the self hit: grow to length 5 via apples, then in consecutive ticks steer down, left, up -> `died`=1 on the up move; with length 4, the same loop moves into the vacating tail cell -> no death.
REQ-037 SHALL cover reset mid-operation: `reset` asserted in RUN and in DEAD -> the REQ-029 state next cycle, including `died`=0.
